// File: rtl/instr_issue_ctrl_pkg.sv
// Shared definitions for the matrix-unit instruction issuer: opcodes, BRAM selects, LOAD size.
package instr_issue_ctrl_pkg;

  localparam int LOAD_BYTES = 64;

  typedef enum logic [3:0] {
    OP_NOP    = 4'h0,
    OP_LOAD   = 4'h4,
    OP_UNLOAD = 4'h5,
    OP_COPY   = 4'h6,
    OP_CLEAR  = 4'h7,
    OP_ADD    = 4'hC,
    OP_SHIFT  = 4'hD,
    OP_SUB    = 4'hE,
    OP_MULT   = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {B0 = 2'd0, B1 = 2'd1, B2 = 2'd2, B3 = 2'd3} bram_sel_e;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} issue_state_e;

  // Any opcode with op[3:2]==0 is treated as a no-op by the control FSM.
  localparam logic [3:0] NOP_MASK = 4'b1100;

  function automatic logic is_nop(input logic [7:0] x);
    return (x[3:0] & NOP_MASK) == 4'b0000;
  endfunction

  // Keeps the DD/AA select bits steady so the datapath muxes do not toggle between ops.
  function automatic logic [7:0] nop_form(input logic [7:0] x);
    return {x[7:4], 4'b0000};
  endfunction

endpackage

// File: rtl/instr_issue_ctrl_fifo.sv
// Synchronous FIFO with registered pointers; head is the raw entry at the read pointer.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/instr_issue_ctrl.sv
// Issue stage ahead of the matrix-unit control FSM: queues instructions and LOAD bytes,
// presents one op at a time and streams LOAD bytes while the FSM is busy.
module instr_issue_ctrl #(
  parameter int CMD_DEPTH  = 4,
  parameter int DATA_DEPTH = 64,
  parameter int LOAD_BYTES = instr_issue_ctrl_pkg::LOAD_BYTES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  output logic       ld_ready,
  input  logic       fsm_busy,
  output logic [7:0] fsm_instr,
  output logic [7:0] load_byte,
  output logic       issuer_idle
);
  import instr_issue_ctrl_pkg::*;

  localparam int CQW = $clog2(CMD_DEPTH);
  localparam int DQW = $clog2(DATA_DEPTH);
  localparam int CW  = $clog2(LOAD_BYTES) + 1;
  localparam logic [DQW:0] LB_D = (DQW+1)'(LOAD_BYTES);
  localparam logic [CW-1:0] LB_C = CW'(LOAD_BYTES);

  issue_state_e  state_q;
  logic [7:0]    held_q;
  logic [CW-1:0] bcnt_q;

  logic [7:0]    cmd_head, ld_head;
  logic          cmd_full, cmd_empty, ld_full, ld_empty;
  logic [CQW:0]  cmd_count;
  logic [DQW:0]  ld_count;
  logic          cmd_pop, ld_pop, issue, head_nop, head_elig;

  sync_fifo #(.WIDTH(8), .DEPTH(CMD_DEPTH)) u_cmd_q (
    .clk     (clk),
    .reset   (reset),
    .push_i  (cmd_valid),
    .data_i  (cmd_data),
    .pop_i   (cmd_pop),
    .head_o  (cmd_head),
    .full_o  (cmd_full),
    .empty_o (cmd_empty),
    .count_o (cmd_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(DATA_DEPTH)) u_ld_q (
    .clk     (clk),
    .reset   (reset),
    .push_i  (ld_valid),
    .data_i  (ld_data),
    .pop_i   (ld_pop),
    .head_o  (ld_head),
    .full_o  (ld_full),
    .empty_o (ld_empty),
    .count_o (ld_count)
  );

  assign cmd_ready   = !cmd_full;
  assign ld_ready    = !ld_full;
  assign load_byte   = ld_empty ? 8'h00 : ld_head;
  assign issuer_idle = cmd_empty && (state_q == S_IDLE) && !fsm_busy;

  always_comb begin
    head_nop  = is_nop(cmd_head);
    // A LOAD only goes out once its whole payload is buffered, so streaming never starves.
    head_elig = (cmd_count != '0) &&
                ((cmd_head[3:0] != OP_LOAD) || (ld_count >= LB_D));
    cmd_pop   = 1'b0;
    issue     = 1'b0;
    fsm_instr = nop_form(held_q);
    if (state_q == S_IDLE) begin
      if ((cmd_count != '0) && head_nop) begin
        cmd_pop = 1'b1;
      end else if (!fsm_busy && head_elig) begin
        issue     = 1'b1;
        cmd_pop   = 1'b1;
        fsm_instr = cmd_head;
      end
    end else if (fsm_busy) begin
      fsm_instr = held_q;
    end
    ld_pop = (state_q == S_RUN) && (held_q[3:0] == OP_LOAD) && fsm_busy && (bcnt_q < LB_C);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      held_q  <= 8'h00;
      bcnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (issue) begin
            state_q <= S_RUN;
            held_q  <= cmd_head;
            bcnt_q  <= '0;
          end
        end
        S_RUN: begin
          if (ld_pop)    bcnt_q  <= bcnt_q + CW'(1);
          // The busy-low cycle is the mandatory gap; nothing issues until back in IDLE.
          if (!fsm_busy) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_issue_ctrl.sv
// Scoreboard bench for instr_issue_ctrl with a behavioural model of the control FSM's busy timing.
module tb_instr_issue_ctrl;
  import instr_issue_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready;
  logic       ld_valid = 1'b0;
  logic [7:0] ld_data = 8'h00;
  logic       ld_ready;
  logic       fsm_busy = 1'b0;
  logic [7:0] fsm_instr;
  logic [7:0] load_byte;
  logic       issuer_idle;

  instr_issue_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_data    (cmd_data),
    .cmd_ready   (cmd_ready),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .fsm_busy    (fsm_busy),
    .fsm_instr   (fsm_instr),
    .load_byte   (load_byte),
    .issuer_idle (issuer_idle)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_cmd[$];
  logic [7:0] exp_byte[$];

  // Monitor-owned model state
  logic [7:0] held = 8'h00;
  int         load_left = 0;
  int         busy_left = 0;
  logic       busy_nxt = 1'b0;
  int         mdl_ld = 0;
  logic       prev_busy = 1'b0;
  logic       prev_issue = 1'b0;
  int         issue_cnt = 0;
  logic       iss;
  int         popd;

  // Driver-owned: forced busy duration for the next issue (-1 = random)
  int force_dur = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Control FSM model: busy from the cycle after issue for a chosen number of cycles.
  initial forever begin
    @(posedge clk);
    #1;
    fsm_busy = busy_nxt;
  end

  // Monitor and scoreboard
  initial forever begin
    @(negedge clk);
    if (reset) begin
      chk("rst_fsm_instr", fsm_instr, 8'h00);
      chk("rst_load_byte", load_byte, 8'h00);
      chk("rst_cmd_ready", cmd_ready, 1'b1);
      chk("rst_ld_ready", ld_ready, 1'b1);
      chk("rst_issuer_idle", issuer_idle, !fsm_busy);
      held = 8'h00; load_left = 0; busy_left = 0; busy_nxt = 1'b0;
      mdl_ld = 0; prev_busy = 1'b0; prev_issue = 1'b0;
    end else begin
      chk("ld_ready", ld_ready, mdl_ld < 64);
      popd = 0;
      iss = !fsm_busy && (fsm_instr[3:2] != 2'b00);
      if (iss) begin
        issue_cnt++;
        chk("issue_expected", exp_cmd.size() != 0, 1'b1);
        if (exp_cmd.size() != 0) chk("issue_instr", fsm_instr, exp_cmd.pop_front());
        chk("issue_gap", {prev_busy, prev_issue}, 2'b00);
        held = fsm_instr;
        if (fsm_instr[3:0] == 4'h4) begin
          chk("load_bytes_ready", mdl_ld >= 64, 1'b1);
          load_left = 64;
          busy_left = (force_dur >= 64) ? force_dur : $urandom_range(64, 67);
        end else begin
          load_left = 0;
          busy_left = (force_dur >= 0) ? force_dur : $urandom_range(0, 4);
        end
      end else if (fsm_busy) begin
        chk("busy_instr", fsm_instr, held);
        if (load_left > 0) begin
          chk("load_byte_avail", exp_byte.size() != 0, 1'b1);
          if (exp_byte.size() != 0) chk("load_byte", load_byte, exp_byte.pop_front());
          load_left--;
          popd = 1;
        end
      end else begin
        chk("nop_instr", fsm_instr, {held[7:4], 4'b0000});
      end
      mdl_ld = mdl_ld + ((ld_valid && ld_ready) ? 1 : 0) - popd;
      prev_busy  = fsm_busy;
      prev_issue = iss;
      busy_nxt   = (busy_left > 0);
      if (busy_left > 0) busy_left--;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    ld_valid = 1'b0;
    exp_cmd.delete();
    exp_byte.delete();
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic push_cmd(input logic [7:0] c);
    int t = 0;
    cmd_valid = 1'b1;
    cmd_data  = c;
    while (!cmd_ready && t < 500) begin tick(); t++; end
    chk("cmd_push_wait", cmd_ready, 1'b1);
    if (cmd_ready && (c[3:2] != 2'b00)) exp_cmd.push_back(c);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    int t = 0;
    ld_valid = 1'b1;
    ld_data  = b;
    while (!ld_ready && t < 500) begin tick(); t++; end
    chk("ld_push_wait", ld_ready, 1'b1);
    if (ld_ready) exp_byte.push_back(b);
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int t = 0;
    cmd_valid = 1'b0;
    ld_valid = 1'b0;
    while ((exp_cmd.size() != 0 || fsm_busy || busy_nxt) && t < 2000) begin tick(); t++; end
    chk({nm, "_drain"}, t < 2000, 1'b1);
    repeat (6) tick();
    chk({nm, "_idle"}, issuer_idle, 1'b1);
  endtask

  // 63 bytes must not release a LOAD; the 64th releases it on the following cycle.
  task automatic load_63_then_1(input logic [7:0] base, input logic [7:0] ld_op);
    int n0;
    for (int i = 0; i < 63; i++) push_byte(base + 8'(i));
    push_cmd(ld_op);
    n0 = issue_cnt;
    repeat (8) tick();
    chk("load63_no_issue", issue_cnt, n0);
    push_byte(base + 8'd63);
    tick();
    chk("load64_issue", issue_cnt, n0 + 1);
  endtask

  function automatic logic [3:0] rand_op();
    int r = $urandom_range(0, 9);
    case (r)
      0:       return 4'($urandom_range(0, 3));
      1:       return OP_LOAD;
      2:       return OP_UNLOAD;
      3:       return OP_COPY;
      4:       return OP_CLEAR;
      5:       return OP_ADD;
      6:       return OP_SHIFT;
      7:       return OP_SUB;
      default: return OP_MULT;
    endcase
  endfunction

  initial begin
    int t;
    logic [7:0] d;
    do_reset();
    chk("post_rst_idle", issuer_idle, 1'b1);

    // ADD with DD/AA select bits
    force_dur = 3;
    push_cmd(8'b01_10_1100);
    wait_idle("add");
    force_dur = -1;

    // LOAD gating on byte count, bytes 0x00..0x3F
    load_63_then_1(8'h00, 8'h04);
    wait_idle("load");

    // Fill the command queue behind a long op
    force_dur = 30;
    push_cmd(8'h6C);
    t = 0;
    while (!fsm_busy && t < 20) begin tick(); t++; end
    chk("long_add_busy", fsm_busy, 1'b1);
    force_dur = -1;
    push_cmd(8'h97);
    push_cmd(8'h26);
    push_cmd(8'hAE);
    push_cmd(8'h5F);
    chk("cmd_ready_full", cmd_ready, 1'b0);
    wait_idle("queue4");

    // NOP between ADD and SUB
    push_cmd(8'h6C);
    push_cmd(8'h02);
    push_cmd(8'hAE);
    wait_idle("nop");

    // Reset in the middle of a LOAD stream
    for (int i = 0; i < 64; i++) push_byte(8'h40 + 8'(i));
    push_cmd(8'h24);
    t = 0;
    while (load_left != 44 && t < 300) begin tick(); t++; end
    chk("load_reach_byte20", load_left, 44);
    do_reset();
    chk("rst_mid_ld_ready", ld_ready, 1'b1);
    chk("rst_mid_idle", issuer_idle, 1'b1);
    load_63_then_1(8'hC0, 8'hD4);
    wait_idle("reload");

    // Keep pushing into a full FIFO while a LOAD drains it
    for (int i = 0; i < 64; i++) push_byte(8'h80 + 8'(i));
    push_cmd(8'h14);
    d = 8'h00;
    ld_valid = 1'b1;
    for (int i = 0; i < 90; i++) begin
      ld_data = d;
      if (ld_ready) begin exp_byte.push_back(d); d++; end
      tick();
    end
    ld_valid = 1'b0;
    t = 0;
    while (ld_ready && t < 70) begin push_byte(d); d++; t++; end
    chk("refill_full", ld_ready, 1'b0);
    push_cmd(8'hB4);
    wait_idle("full_pop");

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_data  = {4'($urandom_range(0, 15)), rand_op()};
      if (cmd_valid && cmd_ready && (cmd_data[3:2] != 2'b00)) exp_cmd.push_back(cmd_data);
      ld_valid = $urandom_range(0, 1) == 1;
      ld_data  = 8'($urandom_range(0, 255));
      if (ld_valid && ld_ready) exp_byte.push_back(ld_data);
      tick();
    end
    cmd_valid = 1'b0;
    t = 0;
    while (exp_cmd.size() != 0 && t < 4000) begin
      ld_valid = $urandom_range(0, 1) == 1;
      ld_data  = 8'($urandom_range(0, 255));
      if (ld_valid && ld_ready) exp_byte.push_back(ld_data);
      tick();
      t++;
    end
    chk("random_drain", t < 4000, 1'b1);
    wait_idle("random");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
